// File: rtl/rgb2hsi_pipe_if.sv
// Pixel stream bundle for rgb2hsi_pipe: stall, input pixel with
// sideband, and the delayed HSI result.
interface rgb2hsi_pipe_if #(
  parameter int DW  = 8,
  parameter int SBW = 3
);
  logic           iEn;
  logic           iValid;
  logic [DW-1:0]  iR;
  logic [DW-1:0]  iG;
  logic [DW-1:0]  iB;
  logic [SBW-1:0] iSide;
  logic           oValid;
  logic [8:0]     oHue;
  logic [DW-1:0]  oSaturation;
  logic [DW-1:0]  oIntensity;
  logic [SBW-1:0] oSide;

  modport master (
    output iEn, iValid, iR, iG, iB, iSide,
    input  oValid, oHue, oSaturation, oIntensity, oSide
  );

  modport slave (
    input  iEn, iValid, iR, iG, iB, iSide,
    output oValid, oHue, oSaturation, oIntensity, oSide
  );
endinterface

// File: rtl/rgb2hsi_pipe.sv
// Pipelined RGB to HSI converter with restoring dividers,
// global stall and aligned valid/sideband delay line.
module rgb2hsi_pipe #(
  parameter int DW  = 8,
  parameter int SBW = 3
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  rgb2hsi_pipe_if.slave bus
);
  localparam int ND  = DW;
  localparam int LAT = DW + 3;
  localparam int XW  = 2*DW + 3;
  localparam int K3  = 3 * ((1 << DW) - 1);
  localparam logic [DW-1:0] MAXV = '1;
  localparam logic [1:0] SEL_B = 2'd0;
  localparam logic [1:0] SEL_R = 2'd1;
  localparam logic [1:0] SEL_G = 2'd2;

  function automatic logic [XW:0] f_step(
    input logic [XW-1:0] rem,
    input logic [XW-1:0] den,
    input int            sh,
    input logic          en
  );
    logic [XW-1:0] d;
    d = den << sh;
    if (en && rem >= d) return {rem - d, 1'b1};
    return {rem, 1'b0};
  endfunction

  logic [DW-1:0]  r1_r, r1_g, r1_b, r1_min;
  logic [DW+1:0]  r1_sum;
  logic [1:0]     r1_sel;
  logic           r1_grey, r1_zero;

  logic [XW-1:0]  r_hrem [0:ND-1];
  logic [XW-1:0]  r_hden [0:ND-1];
  logic [XW-1:0]  r_srem [0:ND-1];
  logic [XW-1:0]  r_sden [0:ND-1];
  logic [XW-1:0]  r_irem [0:ND-1];
  logic [DW-1:0]  r_hq   [1:ND];
  logic [DW-1:0]  r_sq   [1:ND];
  logic [DW-1:0]  r_iq   [1:ND];
  logic [1:0]     r_sel  [0:ND];
  logic           r_grey [0:ND];
  logic           r_zero [0:ND];

  logic [8:0]     r_hue;
  logic [DW-1:0]  r_sat, r_int;
  logic [LAT-1:0] r_vsr;
  logic [SBW-1:0] r_ssr  [0:LAT-1];

  logic [DW-1:0]  w_min;
  logic [DW+1:0]  w_sum;
  logic [1:0]     w_sel;
  logic [XW-1:0]  w_r, w_g, w_b, w_hn, w_hd;
  logic [XW:0]    w_hs [0:ND-1];
  logic [XW:0]    w_ss [0:ND-1];
  logic [XW:0]    w_is [0:ND-1];
  logic [8:0]     w_hoff;

  always_comb begin
    w_sum = (DW+2)'(bus.iR) + (DW+2)'(bus.iG)
          + (DW+2)'(bus.iB);
    w_min = bus.iB;
    unique case (1'b1)
      (bus.iR <= bus.iG && bus.iR <= bus.iB): w_min = bus.iR;
      (bus.iG <  bus.iR && bus.iG <= bus.iB): w_min = bus.iG;
      default:                                w_min = bus.iB;
    endcase
    // equal values resolve to B first, then R
    if (w_min == bus.iB)      w_sel = SEL_B;
    else if (w_min == bus.iR) w_sel = SEL_R;
    else                      w_sel = SEL_G;
  end

  always_comb begin
    w_r  = XW'(r1_r);
    w_g  = XW'(r1_g);
    w_b  = XW'(r1_b);
    w_hn = '0;
    w_hd = '0;
    unique case (r1_sel)
      SEL_B: begin
        w_hn = XW'(120) * (w_g - w_b);
        w_hd = w_r + w_g - (w_b << 1);
      end
      SEL_R: begin
        w_hn = XW'(120) * (w_b - w_r);
        w_hd = w_b + w_g - (w_r << 1);
      end
      default: begin
        w_hn = XW'(120) * (w_r - w_g);
        w_hd = w_b + w_r - (w_g << 1);
      end
    endcase
  end

  // hue quotient never exceeds 120, so only its low 7 bits iterate
  always_comb begin
    for (int k = 0; k < ND; k++) begin
      w_hs[k] = f_step(r_hrem[k], r_hden[k], ND-1-k,
                       (ND-1-k) < 7);
      w_ss[k] = f_step(r_srem[k], r_sden[k], ND-1-k, 1'b1);
      w_is[k] = f_step(r_irem[k], XW'(3), ND-1-k, 1'b1);
    end
  end

  always_comb begin
    w_hoff = 9'd0;
    unique case (r_sel[ND])
      SEL_R:   w_hoff = 9'd120;
      SEL_G:   w_hoff = 9'd240;
      default: w_hoff = 9'd0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r1_r    <= '0;
      r1_g    <= '0;
      r1_b    <= '0;
      r1_min  <= '0;
      r1_sum  <= '0;
      r1_sel  <= '0;
      r1_grey <= 1'b0;
      r1_zero <= 1'b0;
      for (int k = 0; k < ND; k++) begin
        r_hrem[k] <= '0;
        r_hden[k] <= '0;
        r_srem[k] <= '0;
        r_sden[k] <= '0;
        r_irem[k] <= '0;
      end
      for (int k = 1; k <= ND; k++) begin
        r_hq[k] <= '0;
        r_sq[k] <= '0;
        r_iq[k] <= '0;
      end
      for (int k = 0; k <= ND; k++) begin
        r_sel[k]  <= '0;
        r_grey[k] <= 1'b0;
        r_zero[k] <= 1'b0;
      end
      r_hue <= '0;
      r_sat <= '0;
      r_int <= '0;
      r_vsr <= '0;
      for (int k = 0; k < LAT; k++) r_ssr[k] <= '0;
    end else if (bus.iEn) begin
      r1_r    <= bus.iR;
      r1_g    <= bus.iG;
      r1_b    <= bus.iB;
      r1_min  <= w_min;
      r1_sum  <= w_sum;
      r1_sel  <= w_sel;
      r1_grey <= (bus.iR == bus.iG) && (bus.iG == bus.iB);
      r1_zero <= (w_sum == '0);

      r_hrem[0] <= w_hn;
      r_hden[0] <= w_hd;
      r_srem[0] <= XW'(r1_min) * XW'(K3);
      r_sden[0] <= XW'(r1_sum);
      r_irem[0] <= XW'(r1_sum);
      r_sel[0]  <= r1_sel;
      r_grey[0] <= r1_grey;
      r_zero[0] <= r1_zero;

      for (int k = 0; k < ND-1; k++) begin
        r_hrem[k+1] <= w_hs[k][XW:1];
        r_srem[k+1] <= w_ss[k][XW:1];
        r_irem[k+1] <= w_is[k][XW:1];
        r_hden[k+1] <= r_hden[k];
        r_sden[k+1] <= r_sden[k];
      end
      r_hq[1] <= DW'(w_hs[0][0]);
      r_sq[1] <= DW'(w_ss[0][0]);
      r_iq[1] <= DW'(w_is[0][0]);
      for (int k = 1; k < ND; k++) begin
        r_hq[k+1] <= {r_hq[k][DW-2:0], w_hs[k][0]};
        r_sq[k+1] <= {r_sq[k][DW-2:0], w_ss[k][0]};
        r_iq[k+1] <= {r_iq[k][DW-2:0], w_is[k][0]};
      end
      for (int k = 0; k < ND; k++) begin
        r_sel[k+1]  <= r_sel[k];
        r_grey[k+1] <= r_grey[k];
        r_zero[k+1] <= r_zero[k];
      end

      r_hue <= r_grey[ND] ? 9'd0
             : 9'(r_hq[ND][6:0]) + w_hoff;
      r_sat <= r_zero[ND] ? '0 : MAXV - r_sq[ND];
      r_int <= r_iq[ND];

      r_vsr    <= {r_vsr[LAT-2:0], bus.iValid};
      r_ssr[0] <= bus.iSide;
      for (int k = 0; k < LAT-1; k++) r_ssr[k+1] <= r_ssr[k];
    end
  end

  assign bus.oValid      = r_vsr[LAT-1];
  assign bus.oHue        = r_hue;
  assign bus.oSaturation = r_sat;
  assign bus.oIntensity  = r_int;
  assign bus.oSide       = r_ssr[LAT-1];
endmodule

// File: tb/tb_rgb2hsi_pipe.sv
// Directed and model-checked stimulus for rgb2hsi_pipe, DW=8:
// latency, back-to-back flow, stalls, sideband and reset.
module tb_rgb2hsi_pipe;
  localparam int DW  = 8;
  localparam int SBW = 3;
  localparam int LAT = DW + 3;

  typedef struct {
    int h;
    int s;
    int i;
    int sd;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;
  int   snap   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rgb2hsi_pipe_if #(.DW(DW), .SBW(SBW)) bus();

  rgb2hsi_pipe #(.DW(DW), .SBW(SBW)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input int got,
                     input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic int pk();
    return int'({bus.oValid, bus.oHue, bus.oSaturation,
                 bus.oIntensity, bus.oSide});
  endfunction

  function automatic void gold(input int r, input int g,
                               input int b, output int h,
                               output int s, output int i);
    int sum, mn;
    sum = r + g + b;
    if (r <= g && r <= b)     mn = r;
    else if (g < r && g <= b) mn = g;
    else                      mn = b;
    if (r == g && g == b)     h = 0;
    else if (mn == b)         h = 120*(g-b)/(r+g-2*b);
    else if (mn == r)         h = 120*(b-r)/(b+g-2*r) + 120;
    else                      h = 120*(r-g)/(b+r-2*g) + 240;
    s = (sum == 0) ? 0 : 255 - (3*255*mn)/sum;
    i = sum / 3;
  endfunction

  task automatic observe(input bit en);
    exp_t e;
    if (!en) begin
      chk("frz", pk(), snap);
    end else if (bus.oValid) begin
      if (q.size() == 0) begin
        chk("unexp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("hue",  int'(bus.oHue),        e.h);
        chk("sat",  int'(bus.oSaturation), e.s);
        chk("int",  int'(bus.oIntensity),  e.i);
        chk("side", int'(bus.oSide),       e.sd);
        chk("lat",  ecnt,                  e.due);
      end
    end else if (q.size() > 0 && q[0].due <= ecnt) begin
      chk("miss", ecnt, q[0].due);
      void'(q.pop_front());
    end
    snap = pk();
  endtask

  task automatic cyc(input bit en, input bit v,
                     input int r, input int g, input int b,
                     input int sd, input int eh,
                     input int es, input int ei);
    bus.iEn    = en;
    bus.iValid = v;
    bus.iR     = 8'(r);
    bus.iG     = 8'(g);
    bus.iB     = 8'(b);
    bus.iSide  = 3'(sd);
    @(posedge clk);
    if (en && rst_n) begin
      ecnt++;
      if (v) q.push_back('{eh, es, ei, sd, ecnt + LAT - 1});
    end
    #1;
    observe(en);
  endtask

  task automatic px(input int r, input int g, input int b,
                    input int sd, input int eh,
                    input int es, input int ei);
    cyc(1'b1, 1'b1, r, g, b, sd, eh, es, ei);
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 2; k++)
      cyc(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain", q.size(), 0);
  endtask

  task automatic rst_pulse();
    bus.iEn    = 1'b1;
    bus.iValid = 1'b1;
    bus.iR     = 8'd77;
    bus.iG     = 8'd5;
    bus.iB     = 8'd201;
    bus.iSide  = 3'b111;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst", pk(), 0);
    q.delete();
    snap = pk();
  endtask

  initial begin
    int r, g, b, h, s, i, pushed, guard;
    bit en;
    bus.iEn    = 1'b0;
    bus.iValid = 1'b0;
    bus.iR     = '0;
    bus.iG     = '0;
    bus.iB     = '0;
    bus.iSide  = '0;

    rst_pulse();
    rst_pulse();

    px(255, 0, 0, 0, 0, 255, 85);
    drain();

    px(0, 255, 0, 1, 120, 255, 85);
    px(0, 0, 255, 2, 240, 255, 85);
    drain();

    px(128, 128, 128, 3, 0, 0, 128);
    px(0, 0, 0, 4, 0, 0, 0);
    drain();

    px(200, 100, 50, 5, 30, 146, 116);
    px(10, 20, 30, 6, 200, 128, 20);
    px(30, 10, 20, 7, 320, 128, 20);
    px(5, 9, 5, 0, 120, 54, 6);
    px(255, 255, 0, 1, 60, 255, 170);
    drain();

    pushed = 0;
    guard  = 0;
    while (pushed < 32 && guard < 1000) begin
      en = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 255);
      g  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      gold(r, g, b, h, s, i);
      cyc(en, 1'b1, r, g, b, $urandom_range(0, 7), h, s, i);
      if (en) pushed++;
      guard++;
    end
    chk("rnd_cnt", pushed, 32);
    drain();

    px(1, 2, 3, 1, 0, 0, 0);
    px(9, 8, 7, 2, 0, 0, 0);
    px(50, 60, 70, 3, 0, 0, 0);
    px(255, 1, 1, 4, 0, 0, 0);
    px(3, 3, 200, 5, 0, 0, 0);
    rst_pulse();
    px(10, 20, 30, 6, 200, 128, 20);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb2hsi_pipe.md
# rgb2hsi_pipe

Pipelined, parametrised RGB-to-HSI converter for the style-transfer video path. It sits between the camera/RGB demosaic stream and the HSI-domain style filters. It accepts one pixel per enabled clock and produces hue, saturation and intensity after a fixed latency. Compared with the combinational converter, it adds configurable channel width, restoring-divider pipelining that closes timing at pixel clock, valid qualification, a global stall enable, and an aligned sideband passthrough for sync/coordinate bits.

## Interface
- DW, 8, channel width of R/G/B, saturation and intensity; legal range 7..12
- SBW, 3, sideband width (e.g. HS, VS, DE) carried alongside each pixel
- ND (localparam) = DW, number of divider stages; LAT (localparam) = DW + 3, pipeline latency

Ports:
- iCLK  in  1  pixel clock; all state updates on rising edge
- iRST_N  in  1  synchronous, active-low reset
- iEn  in  1  pipeline advance enable; low freezes every stage
- iValid  in  1  iR/iG/iB/iSide carry a pixel this cycle
- iR, iG, iB  in  DW each  unsigned colour channels
- iSide  in  SBW  sideband, delayed by exactly LAT enabled cycles
- oValid  out  1  output pixel valid
- oHue  out  9  hue in degrees, 0..359
- oSaturation  out  DW  saturation, 0..MAXV, where MAXV = 2^DW − 1
- oIntensity  out  DW  intensity, 0..MAXV
- oSide  out  SBW  delayed sideband

## Operation
- sum = R+G+B, DW+2 bits.
- min selection:
  - R if R≤G and R≤B;
  - else G if G<R and G≤B;
  - else B.
- Hue:
  - R==G==B: H = 0.
  - else if min==B: H = floor(120·(G−B)/(R+G−2B)).
  - else if min==R: H = floor(120·(B−R)/(B+G−2R)) + 120.
  - else: H = floor(120·(R−G)/(B+R−2G)) + 240.
  - Branch priority is B, then R, then G, compared by value against min.
- Saturation: sum==0 → 0; else MAXV − floor(3·MAXV·min/sum).
- Intensity: floor(sum/3).
- All divisions are unsigned truncating. Quotients are bounded as follows:
  - hue quotient ≤ 120 (fits 7 bits);
  - saturation quotient ≤ MAXV;
  - intensity ≤ MAXV.
- Pipeline stages:
  - S1: register inputs; compute sum, min, branch select, grey flag and zero-sum flag.
  - S2: form the three numerator/denominator pairs (hue, saturation, intensity/3).
  - S3..S(ND+2): three parallel restoring dividers, one quotient bit per stage, MSB first. The hue divider uses its top DW−7 iterations as leading zeros.
  - S(ND+3): apply grey/zero overrides, add hue offset, subtract saturation quotient; drive outputs.
- Valid and sideband travel in a shift register of LAT entries, in lockstep with data.
- Data stages update regardless of valid. Outputs are only meaningful when oValid=1.

## Timing
- Reset: iRST_N low at a rising edge clears every valid bit and every data/sideband register. oValid, oHue, oSaturation, oIntensity and oSide all read 0 from the next cycle. Reset overrides iEn.
- Latency: a pixel presented with iValid=1 on an edge where iEn=1 appears with oValid=1 after exactly LAT enabled edges (11 for DW=8).
- Throughput: one pixel per enabled cycle, with no bubbles required between pixels.
- iEn=0: no register changes and outputs hold their values, including oValid. Input on that edge is ignored.
- iValid=0 with iEn=1: a bubble propagates; oValid=0 at the matching output slot.
- Reset mid-stream: every in-flight pixel is discarded. The first pixel after release emerges LAT enabled cycles after it enters.
- Simultaneous reset and iEn=1: reset wins.

## Test plan
- DW=8, single pixel (255,0,0), iEn=1 → after 11 cycles: oValid=1, H=0, S=255, I=85. oValid=1 lasts one cycle only.
- Pixels (0,255,0) then (0,0,255) back-to-back → H=120, S=255, I=85, then H=240, S=255, I=85, on consecutive cycles.
- Grey (128,128,128) then black (0,0,0) → H=0, S=0, I=128, then H=0, S=0, I=0. No divide-by-zero artefacts.
- Pixel (200,100,50) with iSide=3'b101 → H=30, S=146, I=116, oSide=3'b101, aligned with oValid.
- Continuous stream of 32 random pixels with iEn toggled pseudo-randomly → outputs match the golden model in order. Outputs are frozen on every iEn=0 cycle.
- iRST_N pulsed low for one cycle while 5 pixels are in flight → oValid=0 and all outputs 0 next cycle. None of the 5 pixels ever appears. A new pixel emerges LAT cycles after its entry.
